// File: rtl/duck_hunt_pkg.sv
// Shared types and widths for the Duck Hunt round sequencer.
// Saturating counter helpers keep the arithmetic out of the FSM body.
package duck_hunt_pkg;

  localparam int AMMO_W     = 3;
  localparam int DUCK_CNT_W = 4;
  localparam int ROUND_W    = 7;
  localparam int ROUND_MAX  = 99;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ROUND_START = 3'd1,
    PAUSE       = 3'd2,
    DUCK_ACTIVE = 3'd3,
    DUCK_GRACE  = 3'd4,
    ROUND_END   = 3'd5,
    GAME_OVER   = 3'd6
  } round_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [DUCK_CNT_W-1:0] hits_inc(input logic [DUCK_CNT_W-1:0] h);
    return (h == {DUCK_CNT_W{1'b1}}) ? h : h + DUCK_CNT_W'(1);
  endfunction

  function automatic logic [ROUND_W-1:0] round_inc(input logic [ROUND_W-1:0] r);
    return (r >= ROUND_W'(ROUND_MAX)) ? r : r + ROUND_W'(1);
  endfunction

endpackage

// File: rtl/delay_timer.sv
// Loadable down-counter shared by the pause, duck-timeout and grace waits.
// done is high whenever the count has drained to zero.
module delay_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/ctl_round.sv
// Duck Hunt round sequencer: ammo, duck timeout, late-hit grace, hit counting
// and round pass/fail, driving the score counter and the duck spawner.
module ctl_round
  import duck_hunt_pkg::*;
#(
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int HITS_TO_PASS    = 6,
  parameter int DUCK_TIMEOUT    = 500_000_000,
  parameter int HIT_GRACE       = 1_000_000,
  parameter int PAUSE_CYCLES    = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  trigger,
  input  logic                  duck_hit,
  output logic                  spawn_duck,
  output logic                  duck_active,
  output logic                  score_hit,
  output logic                  reset_score,
  output logic [AMMO_W-1:0]     ammo,
  output logic [DUCK_CNT_W-1:0] ducks_left,
  output logic [DUCK_CNT_W-1:0] hits,
  output logic [ROUND_W-1:0]    round_num,
  output logic                  game_over
);

  localparam int MAX_WAIT = max3(DUCK_TIMEOUT, HIT_GRACE, PAUSE_CYCLES);
  localparam int TW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  // A wait of N cycles loads N-1 on the entering edge and ends on done.
  localparam logic [TW-1:0] PAUSE_LOAD   = TW'(PAUSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(DUCK_TIMEOUT - 1);
  localparam logic [TW-1:0] GRACE_LOAD   = TW'(HIT_GRACE - 1);

  localparam logic [AMMO_W-1:0]     FULL_AMMO  = AMMO_W'(SHOTS_PER_DUCK);
  localparam logic [AMMO_W-1:0]     LAST_SHOT  = AMMO_W'(1);
  localparam logic [DUCK_CNT_W-1:0] ROUND_SIZE = DUCK_CNT_W'(DUCKS_PER_ROUND);
  localparam logic [DUCK_CNT_W-1:0] PASS_HITS  = DUCK_CNT_W'(HITS_TO_PASS);

  round_state_t          state_reg;
  logic                  spawn_duck_reg;
  logic                  duck_active_reg;
  logic                  score_hit_reg;
  logic                  reset_score_reg;
  logic [AMMO_W-1:0]     ammo_reg;
  logic [DUCK_CNT_W-1:0] ducks_left_reg;
  logic [DUCK_CNT_W-1:0] hits_reg;
  logic [ROUND_W-1:0]    round_num_reg;
  logic                  game_over_reg;

  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_en;
  logic          timer_done;
  logic          last_shot;

  assign last_shot = (state_reg == DUCK_ACTIVE) && trigger && (ammo_reg == LAST_SHOT);
  assign timer_en  = (state_reg != IDLE) && (state_reg != GAME_OVER);

  // Reloads the shared timer on exactly the edges where the FSM enters a wait.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_reg)
      IDLE, GAME_OVER: begin
        if (start) begin
          timer_load = 1'b1;
          timer_val  = PAUSE_LOAD;
        end
      end
      ROUND_START: begin
        if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = TIMEOUT_LOAD;
        end
      end
      DUCK_ACTIVE, DUCK_GRACE: begin
        if (duck_hit || timer_done) begin
          timer_load = 1'b1;
          timer_val  = PAUSE_LOAD;
        end else if (last_shot) begin
          timer_load = 1'b1;
          timer_val  = GRACE_LOAD;
        end
      end
      PAUSE: begin
        if (timer_done && (ducks_left_reg != '0)) begin
          timer_load = 1'b1;
          timer_val  = TIMEOUT_LOAD;
        end
      end
      ROUND_END: begin
        if (hits_reg >= PASS_HITS) begin
          timer_load = 1'b1;
          timer_val  = PAUSE_LOAD;
        end
      end
      default: begin
        timer_load = 1'b0;
        timer_val  = '0;
      end
    endcase
  end

  delay_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      spawn_duck_reg  <= 1'b0;
      duck_active_reg <= 1'b0;
      score_hit_reg   <= 1'b0;
      reset_score_reg <= 1'b0;
      ammo_reg        <= '0;
      ducks_left_reg  <= '0;
      hits_reg        <= '0;
      round_num_reg   <= ROUND_W'(1);
      game_over_reg   <= 1'b0;
    end else begin
      spawn_duck_reg  <= 1'b0;
      score_hit_reg   <= 1'b0;
      reset_score_reg <= 1'b0;
      case (state_reg)
        IDLE, GAME_OVER: begin
          if (start) begin
            state_reg       <= ROUND_START;
            reset_score_reg <= 1'b1;
            round_num_reg   <= ROUND_W'(1);
            hits_reg        <= '0;
            ducks_left_reg  <= ROUND_SIZE;
            game_over_reg   <= 1'b0;
          end
        end
        ROUND_START: begin
          if (timer_done) begin
            state_reg       <= DUCK_ACTIVE;
            spawn_duck_reg  <= 1'b1;
            ammo_reg        <= FULL_AMMO;
            duck_active_reg <= 1'b1;
          end
        end
        DUCK_ACTIVE, DUCK_GRACE: begin
          if ((state_reg == DUCK_ACTIVE) && trigger && (ammo_reg != '0)) begin
            ammo_reg <= ammo_reg - AMMO_W'(1);
          end
          // A hit beats both the timeout and the last shot on the same cycle.
          if (duck_hit) begin
            state_reg       <= PAUSE;
            score_hit_reg   <= 1'b1;
            hits_reg        <= hits_inc(hits_reg);
            duck_active_reg <= 1'b0;
            ducks_left_reg  <= ducks_left_reg - DUCK_CNT_W'(1);
          end else if (timer_done) begin
            state_reg       <= PAUSE;
            duck_active_reg <= 1'b0;
            ducks_left_reg  <= ducks_left_reg - DUCK_CNT_W'(1);
          end else if (last_shot) begin
            state_reg <= DUCK_GRACE;
          end
        end
        PAUSE: begin
          if (timer_done) begin
            if (ducks_left_reg != '0) begin
              state_reg       <= DUCK_ACTIVE;
              spawn_duck_reg  <= 1'b1;
              ammo_reg        <= FULL_AMMO;
              duck_active_reg <= 1'b1;
            end else begin
              state_reg <= ROUND_END;
            end
          end
        end
        ROUND_END: begin
          if (hits_reg >= PASS_HITS) begin
            state_reg      <= ROUND_START;
            round_num_reg  <= round_inc(round_num_reg);
            ducks_left_reg <= ROUND_SIZE;
            hits_reg       <= '0;
          end else begin
            state_reg     <= GAME_OVER;
            game_over_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign spawn_duck  = spawn_duck_reg;
  assign duck_active = duck_active_reg;
  assign score_hit   = score_hit_reg;
  assign reset_score = reset_score_reg;
  assign ammo        = ammo_reg;
  assign ducks_left  = ducks_left_reg;
  assign hits        = hits_reg;
  assign round_num   = round_num_reg;
  assign game_over   = game_over_reg;

endmodule

// File: tb/tb_ctl_round.sv
// Randomized bench for ctl_round against a phase/age reference model of the game rules.
module tb_ctl_round;

  localparam int SPD  = 3;
  localparam int DPR  = 3;
  localparam int PASS = 2;
  localparam int TMO  = 20;
  localparam int GR   = 3;
  localparam int PC   = 4;

  localparam int P_IDLE  = 0;
  localparam int P_RS    = 1;
  localparam int P_DUCK  = 2;
  localparam int P_GRACE = 3;
  localparam int P_PAUSE = 4;
  localparam int P_END   = 5;
  localparam int P_OVER  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       trigger = 1'b0;
  logic       duck_hit = 1'b0;
  logic       spawn_duck, duck_active, score_hit, reset_score, game_over;
  logic [2:0] ammo;
  logic [3:0] ducks_left, hits;
  logic [6:0] round_num;

  ctl_round #(
    .SHOTS_PER_DUCK  (SPD),
    .DUCKS_PER_ROUND (DPR),
    .HITS_TO_PASS    (PASS),
    .DUCK_TIMEOUT    (TMO),
    .HIT_GRACE       (GR),
    .PAUSE_CYCLES    (PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .trigger     (trigger),
    .duck_hit    (duck_hit),
    .spawn_duck  (spawn_duck),
    .duck_active (duck_active),
    .score_hit   (score_hit),
    .reset_score (reset_score),
    .ammo        (ammo),
    .ducks_left  (ducks_left),
    .hits        (hits),
    .round_num   (round_num),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: game phase plus cycles spent in it.
  int m_phase, m_age, m_ammo, m_ducks, m_hits, m_round;
  int m_active, m_over, m_spawn, m_score, m_rscore;

  int trig_pct  = 25;
  int hit_pct   = 10;
  int start_div = 20;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_phase = P_IDLE; m_age = 0; m_ammo = 0; m_ducks = 0; m_hits = 0; m_round = 1;
    m_active = 0; m_over = 0; m_spawn = 0; m_score = 0; m_rscore = 0;
  endfunction

  function automatic void start_round();
    m_phase = P_RS; m_age = 0; m_ducks = DPR; m_hits = 0;
  endfunction

  function automatic void enter_duck();
    m_phase = P_DUCK; m_age = 0; m_ammo = SPD; m_active = 1; m_spawn = 1;
  endfunction

  function automatic void leave_duck(input bit scored);
    if (scored) begin
      m_score = 1;
      m_hits  = (m_hits < 15) ? m_hits + 1 : 15;
    end
    m_active = 0; m_ducks = m_ducks - 1; m_phase = P_PAUSE; m_age = 0;
    $display("duck round=%0d %s hits=%0d ducks_left=%0d", m_round, scored ? "hit " : "miss", m_hits, m_ducks);
  endfunction

  function automatic void model_step(input bit s, input bit t, input bit h);
    m_spawn = 0; m_score = 0; m_rscore = 0;
    case (m_phase)
      P_IDLE, P_OVER: if (s) begin
        m_rscore = 1; m_round = 1; m_over = 0; start_round();
        $display("game start");
      end
      P_RS: if (m_age == PC - 1) enter_duck(); else m_age++;
      P_DUCK: begin
        if (t && m_ammo > 0) m_ammo--;
        if (h) leave_duck(1);
        else if (m_age == TMO - 1) leave_duck(0);
        else if (m_ammo == 0) begin m_phase = P_GRACE; m_age = 0; end
        else m_age++;
      end
      P_GRACE: begin
        if (h) leave_duck(1);
        else if (m_age == GR - 1) leave_duck(0);
        else m_age++;
      end
      P_PAUSE: begin
        if (m_age == PC - 1) begin
          if (m_ducks > 0) enter_duck(); else m_phase = P_END;
        end else m_age++;
      end
      P_END: begin
        if (m_hits >= PASS) begin
          m_round = (m_round < 99) ? m_round + 1 : 99;
          start_round();
          $display("round passed, next round=%0d", m_round);
        end else begin
          m_phase = P_OVER; m_over = 1;
          $display("round failed, game over at round=%0d", m_round);
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endfunction

  task automatic check_outputs();
    check_val("spawn_duck",  int'(spawn_duck),  m_spawn);
    check_val("duck_active", int'(duck_active), m_active);
    check_val("score_hit",   int'(score_hit),   m_score);
    check_val("reset_score", int'(reset_score), m_rscore);
    check_val("ammo",        int'(ammo),        m_ammo);
    check_val("ducks_left",  int'(ducks_left),  m_ducks);
    check_val("hits",        int'(hits),        m_hits);
    check_val("round_num",   int'(round_num),   m_round);
    check_val("game_over",   int'(game_over),   m_over);
  endtask

  task automatic run_cycle();
    @(negedge clk);
    start    = ($urandom_range(0, start_div - 1) == 0);
    trigger  = ($urandom_range(0, 99) < trig_pct);
    duck_hit = ($urandom_range(0, 99) < hit_pct);
    @(posedge clk);
    if (rst) model_step(start, trigger, duck_hit);
    else model_reset();
    #1 check_outputs();
  endtask

  // Drop rst mid-cycle while the duck has one shot left, then verify quiet release.
  task automatic reset_on_last_shot();
    int n;
    n = 0;
    trig_pct = 30; hit_pct = 3; start_div = 10;
    while (!(m_phase == P_DUCK && m_ammo == 1) && n < 3000) begin
      run_cycle();
      n++;
    end
    if (n >= 3000) begin
      check_val("wait_ammo1_budget", n, 0);
    end else begin
      check_val("ammo_before_rst", int'(ammo), 1);
      @(negedge clk);
      start = 1'b0; trigger = 1'b1; duck_hit = 1'b1;
      #2 rst = 1'b0;
      model_reset();
      #1 check_outputs();
      @(posedge clk);
      #1 check_outputs();
      @(negedge clk);
      rst = 1'b1;
      start_div = 1000000;
      repeat (6) run_cycle();
      $display("async reset on last shot done");
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b1;

    for (int chunk = 0; chunk < 8; chunk++) begin
      int tp[8] = '{25, 0, 50, 10, 30, 5, 60, 20};
      int hp[8] = '{12, 5, 8, 3, 20, 2, 10, 6};
      trig_pct  = tp[chunk];
      hit_pct   = hp[chunk];
      start_div = 20;
      for (int c = 0; c < 1200; c++) run_cycle();
      reset_on_last_shot();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
